pn_age_scheduler: RTL and testbench
===================================

PN_AGE_SCHEDULER -- requirements
Module: pn_age_scheduler

Interface
REQ-001 Parameter TIME_WIDTH, default `TIME_WIDTH` from global.vh, width of each flit age/time field.
REQ-002 Parameter CNT_WIDTH, default 16, width of the deflection statistics counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  1 freezes every pipeline register, rr_ptr and defl_cnt.
REQ-006 in_valid  input  4  bit i = input slot i carries a flit this cycle.
REQ-007 in_time0..in_time3  input  TIME_WIDTH each  flit timestamp; smaller value = older.
REQ-008 in_prod0..in_prod3  input  4 each  productive output-port mask for slot i (bit p = port p productive).
REQ-009 out_valid  output  4  bit i = slot i result valid.
REQ-010 out_port0..out_port3  output  2 each  output port assigned to slot i.
REQ-011 out_defl  output  4  bit i = slot i assigned a non-productive port.
REQ-012 out_rank0..out_rank3  output  2 each  slot index of the k-th oldest flit (rank0 = oldest).
REQ-013 defl_cnt  output  CNT_WIDTH  saturating count of deflections issued.

Function
REQ-014 Two-stage pipeline (S1 sort, S2 allocate); results for inputs sampled at edge T appear on outputs after edge T+2 (latency 2) when stall is 0 throughout.
REQ-015 stall=1: no register changes; outputs hold their values; inputs presented that cycle are dropped.
REQ-016 S1 captures in_valid, times and masks, then ranks all 4 slots: valid before invalid; among valid, smaller time first (unsigned compare).
REQ-017 Equal times among valid slots: tie broken by rotating priority starting at rr_ptr (order rr_ptr, rr_ptr+1, ... mod 4); same rule orders invalid slots among themselves.
REQ-018 rr_ptr is 2 bits, increments by 1 mod 4 (3 -> 0) on every non-stalled edge on which S1 holds at least one valid slot.
REQ-019 S2 allocates ports in rank order: each valid slot takes the lowest-numbered free port in its mask; if none is free it takes the lowest-numbered free port overall and its out_defl bit is 1.
REQ-020 Each port is granted to at most one slot per cycle; with 4 slots and 4 ports every valid slot always receives a port.
REQ-021 A valid slot with in_prod = 4'b0000 is always deflected.
REQ-022 Invalid slots: out_valid=0, out_port=0, out_defl=0; they consume no port.
REQ-023 out_rank0..3 is always a permutation of {0,1,2,3}, including when all slots are invalid.
REQ-024 defl_cnt adds popcount(out_defl) of the newly registered S2 result on each non-stalled edge; saturates at all-ones and never wraps.
REQ-025 All outputs are registered; no combinational input-to-output path.

Reset
REQ-026 Reset is applied on the edge while reset=1 and overrides stall.
REQ-027 Reset values: out_valid=0, out_port*=0, out_defl=0, out_rank0..3=0,1,2,3, defl_cnt=0, rr_ptr=0, S1 valid bits=0.
REQ-028 Reset asserted mid-operation discards all in-flight flits; the first results after deassertion come only from inputs sampled after reset.

Verification
REQ-029 Distinct ages: valid=1111, times 5,2,9,7, all masks=0001 -> after 2 edges rank=1,0,3,2; slot1 port0 defl=0; slots 0,3,2 ports 1,2,3 defl=1; defl_cnt=3.
REQ-030 Tie with rotation: reset, then two cycles of valid=0011, times 4,4, masks 0001 -> first result slot0 port0 and slot1 deflected; second result slot1 port0 and slot0 deflected (rr_ptr=1).
REQ-031 Partial valid: valid=0100, time2=0, mask2=1000 -> out_valid=0100, out_port2=3, out_defl=0, rank0=2, other ports unused.
REQ-032 Stall: drive data, raise stall for 3 cycles mid-pipeline -> outputs and defl_cnt frozen; results emerge 2 non-stalled edges after capture; inputs offered during stall produce no result.
REQ-033 Saturation: CNT_WIDTH=4, 6 cycles of valid=1111 with all masks=0001 (3 deflections each) -> defl_cnt reaches 15 and stays 15.
REQ-034 Reset mid-flight: valid=1111 sampled, reset on next edge -> outputs take REQ-027 values; no result from the pre-reset flits ever appears.

Source files
------------

// File: rtl/pn_age_scheduler.sv
// rtl/pn_age_scheduler.sv - age-ordered port allocator for 4 flit slots
// Capture, sort-by-age and allocate stages; all outputs come straight from flops.
module pn_age_scheduler #(
  parameter int TIME_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [3:0]            in_valid,
  input  logic [TIME_WIDTH-1:0] in_time0,
  input  logic [TIME_WIDTH-1:0] in_time1,
  input  logic [TIME_WIDTH-1:0] in_time2,
  input  logic [TIME_WIDTH-1:0] in_time3,
  input  logic [3:0]            in_prod0,
  input  logic [3:0]            in_prod1,
  input  logic [3:0]            in_prod2,
  input  logic [3:0]            in_prod3,
  output logic [3:0]            out_valid,
  output logic [1:0]            out_port0,
  output logic [1:0]            out_port1,
  output logic [1:0]            out_port2,
  output logic [1:0]            out_port3,
  output logic [3:0]            out_defl,
  output logic [1:0]            out_rank0,
  output logic [1:0]            out_rank1,
  output logic [1:0]            out_rank2,
  output logic [1:0]            out_rank3,
  output logic [CNT_WIDTH-1:0]  defl_cnt
);

  logic [TIME_WIDTH-1:0] in_time [4];
  logic [3:0]            in_prod [4];

  assign in_time[0] = in_time0;
  assign in_time[1] = in_time1;
  assign in_time[2] = in_time2;
  assign in_time[3] = in_time3;
  assign in_prod[0] = in_prod0;
  assign in_prod[1] = in_prod1;
  assign in_prod[2] = in_prod2;
  assign in_prod[3] = in_prod3;

  logic [3:0]            s1_valid;
  logic [TIME_WIDTH-1:0] s1_time [4];
  logic [3:0]            s1_prod [4];
  logic [1:0]            rr_ptr;

  logic [3:0]            s2_valid;
  logic [3:0]            s2_prod [4];
  logic [1:0]            s2_rank [4];

  logic [1:0]            port_q [4];
  logic [1:0]            rank_q [4];

  // Slot j goes ahead of slot i: valid first, then older time, then round-robin priority.
  function automatic logic ahead(input logic vj, input logic vi,
                                 input logic [TIME_WIDTH-1:0] tj, input logic [TIME_WIDTH-1:0] ti,
                                 input logic [1:0] pj, input logic [1:0] pi);
    if (vj != vi) return vj;
    if (vj && (tj != ti)) return tj < ti;
    return pj < pi;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  logic [1:0] pos [4];
  logic [1:0] sorted_rank [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pos[i] = '0;
      for (int j = 0; j < 4; j++) begin
        if ((j != i) && ahead(s1_valid[j], s1_valid[i], s1_time[j], s1_time[i],
                              2'(j) - rr_ptr, 2'(i) - rr_ptr))
          pos[i] = pos[i] + 2'd1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      sorted_rank[k] = '0;
      for (int i = 0; i < 4; i++)
        if (pos[i] == 2'(k)) sorted_rank[k] = 2'(i);
    end
  end

  logic [1:0] next_port [4];
  logic [3:0] next_defl;
  logic [3:0] free;
  logic [3:0] avail;
  logic [1:0] slot;
  logic [1:0] pick;

  always_comb begin
    free      = 4'hf;
    next_defl = '0;
    avail     = '0;
    slot      = '0;
    pick      = '0;
    for (int i = 0; i < 4; i++) next_port[i] = '0;
    for (int k = 0; k < 4; k++) begin
      slot  = s2_rank[k];
      avail = free & s2_prod[slot];
      if (s2_valid[slot]) begin
        if (avail != 4'd0) begin
          pick = lowest(avail);
        end else begin
          pick            = lowest(free);
          next_defl[slot] = 1'b1;
        end
        next_port[slot] = pick;
        free[pick]      = 1'b0;
      end
    end
  end

  logic [2:0]           defl_pop;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;

  always_comb begin
    defl_pop = {2'b0, next_defl[0]} + {2'b0, next_defl[1]}
             + {2'b0, next_defl[2]} + {2'b0, next_defl[3]};
    cnt_sum  = {1'b0, defl_cnt} + (CNT_WIDTH+1)'(defl_pop);
    cnt_next = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= '0;
      rr_ptr    <= '0;
      s2_valid  <= '0;
      out_valid <= '0;
      out_defl  <= '0;
      defl_cnt  <= '0;
      for (int i = 0; i < 4; i++) begin
        s2_rank[i] <= 2'(i);
        rank_q[i]  <= 2'(i);
        port_q[i]  <= '0;
      end
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (|s1_valid) rr_ptr <= rr_ptr + 2'd1;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_defl  <= next_defl;
      defl_cnt  <= cnt_next;
      for (int i = 0; i < 4; i++) begin
        s1_time[i] <= in_time[i];
        s1_prod[i] <= in_prod[i];
        s2_prod[i] <= s1_prod[i];
        s2_rank[i] <= sorted_rank[i];
        rank_q[i]  <= s2_rank[i];
        port_q[i]  <= next_port[i];
      end
    end
  end

  assign out_port0 = port_q[0];
  assign out_port1 = port_q[1];
  assign out_port2 = port_q[2];
  assign out_port3 = port_q[3];
  assign out_rank0 = rank_q[0];
  assign out_rank1 = rank_q[1];
  assign out_rank2 = rank_q[2];
  assign out_rank3 = rank_q[3];

endmodule

// File: tb/tb_pn_age_scheduler.sv
// tb/tb_pn_age_scheduler.sv - randomized bench with queue-based reference model
module tb_pn_age_scheduler;
  localparam int TW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, stall;
  logic [3:0]    in_valid;
  logic [TW-1:0] in_time0, in_time1, in_time2, in_time3;
  logic [3:0]    in_prod0, in_prod1, in_prod2, in_prod3;
  logic [3:0]    out_valid, out_defl;
  logic [1:0]    out_port0, out_port1, out_port2, out_port3;
  logic [1:0]    out_rank0, out_rank1, out_rank2, out_rank3;
  logic [CW-1:0] defl_cnt;

  pn_age_scheduler #(.TIME_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
    .in_time0(in_time0), .in_time1(in_time1), .in_time2(in_time2), .in_time3(in_time3),
    .in_prod0(in_prod0), .in_prod1(in_prod1), .in_prod2(in_prod2), .in_prod3(in_prod3),
    .out_valid(out_valid), .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .out_port3(out_port3), .out_defl(out_defl),
    .out_rank0(out_rank0), .out_rank1(out_rank1), .out_rank2(out_rank2),
    .out_rank3(out_rank3), .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  v;
    logic [15:0] t;
    logic [15:0] m;
    logic [1:0]  rr;
  } txn_t;

  txn_t q[$];
  txn_t cur, tmp;
  int   m_rr;
  logic [3:0] exp_valid, exp_defl;
  int   exp_port [4];
  int   exp_rank [4];
  int   exp_cnt;

  // Sort slots by (invalid, age, rotated index) and hand out ports greedily in that order.
  task automatic evaluate(input txn_t x);
    int order [4];
    int key [4];
    int sw, s, pick, ndefl;
    logic [3:0] free, mask;
    for (int i = 0; i < 4; i++) begin
      order[i] = i;
      key[i] = (x.v[i] ? 0 : 1024) + (x.v[i] ? 4 * int'(x.t[i*4 +: 4]) : 0)
             + ((i - int'(x.rr) + 4) % 4);
    end
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3 - a; b++)
        if (key[order[b]] > key[order[b+1]]) begin
          sw = order[b]; order[b] = order[b+1]; order[b+1] = sw;
        end
    free = 4'hf;
    ndefl = 0;
    exp_valid = x.v;
    exp_defl = '0;
    for (int i = 0; i < 4; i++) begin
      exp_port[i] = 0;
      exp_rank[i] = order[i];
    end
    for (int k = 0; k < 4; k++) begin
      s = order[k];
      if (x.v[s]) begin
        mask = x.m[s*4 +: 4];
        pick = -1;
        for (int p = 0; p < 4; p++) if (pick < 0 && free[p] && mask[p]) pick = p;
        if (pick < 0) begin
          exp_defl[s] = 1'b1;
          ndefl++;
          for (int p = 0; p < 4; p++) if (pick < 0 && free[p]) pick = p;
        end
        exp_port[s] = pick;
        free[pick] = 1'b0;
      end
    end
    exp_cnt = (exp_cnt + ndefl > 15) ? 15 : exp_cnt + ndefl;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_rr = 0;
      exp_valid = '0;
      exp_defl = '0;
      exp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        exp_port[i] = 0;
        exp_rank[i] = i;
      end
    end else if (!stall) begin
      if (q.size() == 2) evaluate(q.pop_front());
      if (q.size() == 1) begin
        tmp = q[0];
        tmp.rr = 2'(m_rr);
        q[0] = tmp;
        if (|tmp.v) m_rr = (m_rr + 1) % 4;
      end
      cur.v = in_valid;
      cur.t = {in_time3, in_time2, in_time1, in_time0};
      cur.m = {in_prod3, in_prod2, in_prod1, in_prod0};
      cur.rr = '0;
      q.push_back(cur);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", out_valid, exp_valid);
      check("defl", out_defl, exp_defl);
      check("port0", out_port0, exp_port[0]);
      check("port1", out_port1, exp_port[1]);
      check("port2", out_port2, exp_port[2]);
      check("port3", out_port3, exp_port[3]);
      check("rank0", out_rank0, exp_rank[0]);
      check("rank1", out_rank1, exp_rank[1]);
      check("rank2", out_rank2, exp_rank[2]);
      check("rank3", out_rank3, exp_rank[3]);
      check("cnt", defl_cnt, exp_cnt);
    end
  end

  task automatic step(input logic rst, input logic stl, input logic [3:0] v,
                      input logic [15:0] t, input logic [15:0] m);
    reset = rst; stall = stl; in_valid = v;
    in_time0 = t[3:0];  in_time1 = t[7:4];  in_time2 = t[11:8];  in_time3 = t[15:12];
    in_prod0 = m[3:0];  in_prod1 = m[7:4];  in_prod2 = m[11:8];  in_prod3 = m[15:12];
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_defl"}, out_defl, 0);
    check({tag, "_ports"}, {out_port3, out_port2, out_port1, out_port0}, 0);
    check({tag, "_ranks"}, {out_rank3, out_rank2, out_rank1, out_rank0}, 8'b11_10_01_00);
    check({tag, "_cnt"}, defl_cnt, 0);
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check_reset_state("reset");

    // distinct ages, every slot wants port 0
    step(1'b0, 1'b0, 4'hf, {4'd7, 4'd9, 4'd2, 4'd5}, 16'h1111);
    idle(); idle();
    check("age_ranks", {out_rank3, out_rank2, out_rank1, out_rank0}, {2'd2, 2'd3, 2'd0, 2'd1});
    check("age_ports", {out_port3, out_port2, out_port1, out_port0}, {2'd2, 2'd3, 2'd0, 2'd1});
    check("age_defl", out_defl, 4'b1101);
    check("age_cnt", defl_cnt, 3);

    // equal ages resolved by rotating pointer
    do_reset();
    step(1'b0, 1'b0, 4'h3, {8'h0, 4'd4, 4'd4}, 16'h0011);
    step(1'b0, 1'b0, 4'h3, {8'h0, 4'd4, 4'd4}, 16'h0011);
    idle();
    check("tie1_ports", {out_port1, out_port0}, {2'd1, 2'd0});
    check("tie1_defl", out_defl, 4'b0010);
    check("tie1_cnt", defl_cnt, 1);
    idle();
    check("tie2_ports", {out_port1, out_port0}, {2'd0, 2'd1});
    check("tie2_defl", out_defl, 4'b0001);
    check("tie2_rank0", out_rank0, 1);
    check("tie2_cnt", defl_cnt, 2);

    // single valid slot
    do_reset();
    step(1'b0, 1'b0, 4'h4, 16'h0, 16'h0800);
    idle(); idle();
    check("part_valid", out_valid, 4'b0100);
    check("part_ports", {out_port3, out_port2, out_port1, out_port0}, {2'd0, 2'd3, 2'd0, 2'd0});
    check("part_defl", out_defl, 0);
    check("part_rank0", out_rank0, 2);

    // stall mid-pipeline, inputs offered during stall are lost
    do_reset();
    step(1'b0, 1'b0, 4'hf, {4'd0, 4'd2, 4'd1, 4'd3}, {4'b0001, 4'b1000, 4'b0100, 4'b0010});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'hf, 16'h1234, 16'h1111);
      check("stall_frozen_valid", out_valid, 0);
    end
    idle();
    check("stall_not_yet", out_valid, 0);
    idle();
    check("stall_valid", out_valid, 4'hf);
    check("stall_ports", {out_port3, out_port2, out_port1, out_port0}, {2'd0, 2'd3, 2'd2, 2'd1});
    check("stall_ranks", {out_rank3, out_rank2, out_rank1, out_rank0}, {2'd0, 2'd2, 2'd1, 2'd3});
    check("stall_defl", out_defl, 0);
    idle();
    check("stall_dropped", out_valid, 0);
    check("stall_cnt", defl_cnt, 0);

    // counter saturation at 15
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'hf, 16'($urandom), 16'h1111);
    check("sat_cnt12", defl_cnt, 12);
    idle(); idle();
    check("sat_cnt15", defl_cnt, 15);
    step(1'b0, 1'b0, 4'hf, 16'h0, 16'h0000);
    idle(); idle();
    check("sat_hold", defl_cnt, 15);

    // reset with flits in flight
    do_reset();
    step(1'b0, 1'b0, 4'hf, 16'h4321, 16'h1111);
    step(1'b1, 1'b0, 4'hf, 16'h4321, 16'h1111);
    check_reset_state("midrst");
    for (int i = 0; i < 3; i++) begin
      idle();
      check("midrst_no_result", out_valid, 0);
    end
    check("midrst_cnt", defl_cnt, 0);

    // randomized traffic with occasional stall and reset
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
           4'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 59) == 0) do_reset();
    end
    idle(); idle();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
